// File: rtl/tw_pkg.sv
// Shared types for the twiddle fetch sequencer: FSM encoding, default widths
// and the layout of one buffered twiddle entry.
package tw_pkg;

  localparam int IDX_W_DEF = 5;
  localparam int TW_W_DEF  = 25;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ADV   = 3'd3,
    DRAIN = 3'd4
  } tw_state_e;

  // Field order matches the packing used when pushing into the FIFO.
  typedef struct packed {
    logic [TW_W_DEF-1:0]  tw;
    logic [IDX_W_DEF-1:0] stage;
    logic [IDX_W_DEF-1:0] index;
    logic                 last;
  } tw_entry_t;

endpackage

// File: rtl/tw_fifo.sv
// Small synchronous FIFO with occupancy count; write is dropped when full and
// read is ignored when empty, so the pointers can wrap freely.
module tw_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the head is masked by empty at the top level.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tw_fetch_sequencer.sv
// Walks every (stage, index) pair of an N-point NTT, requests each twiddle from
// the generator one at a time and buffers the results for the butterfly.
module tw_fetch_sequencer
  import tw_pkg::*;
#(
  parameter int IDX_W       = IDX_W_DEF,
  parameter int TW_W        = TW_W_DEF,
  parameter int N_PTS       = 8,
  parameter int LOGN        = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          run,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout,
  output logic [IDX_W-1:0]              tw_j,
  output logic [IDX_W-1:0]              tw_i,
  output logic [IDX_W-1:0]              tw_N,
  output logic                          tw_start,
  input  logic                          tw_ack,
  input  logic [TW_W-1:0]               tw_data,
  output logic                          tw_valid,
  input  logic                          tw_ready,
  output logic [TW_W-1:0]               tw_out,
  output logic [IDX_W-1:0]              tw_stage,
  output logic [IDX_W-1:0]              tw_index,
  output logic                          tw_last,
  output tw_state_e                     dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_count
);

  // Handshake: the generator sees one tw_start pulse per request and answers
  // with a rising edge on tw_ack; downstream, an entry moves on any cycle where
  // tw_valid and tw_ready are both high, and tw_valid never depends on tw_ready.

  localparam int ENT_W = TW_W + 2*IDX_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  tw_state_e               state, state_nx;
  logic [IDX_W-1:0]        i_q, j_q;
  logic [TMR_W-1:0]        timer;
  logic                    ack_q, busy_q, done_q, err_q;
  logic                    ack_rise, pair_last, j_end, timeout_hit;
  logic [IDX_W-1:0]        stage_len;
  logic                    accept, issue, push, finish, tmo;
  logic                    fifo_full, fifo_empty, pop, pop_last;
  logic [ENT_W-1:0]        push_ent, head_ent;
  logic [TW_W-1:0]         head_tw;
  logic [IDX_W-1:0]        head_stage, head_index;
  logic                    head_last;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign ack_rise    = tw_ack & ~ack_q;
  assign stage_len   = IDX_W'(N_PTS >> (int'(i_q) + 1));
  assign j_end       = (j_q == stage_len - IDX_W'(1));
  assign pair_last   = (i_q == IDX_W'(LOGN - 1));
  assign timeout_hit = (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign pop         = tw_valid & tw_ready;
  assign pop_last    = pop & head_last;
  assign push_ent    = {tw_data, i_q, j_q, pair_last};
  assign {head_tw, head_stage, head_index, head_last} = head_ent;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (run) state_nx = ISSUE;
      ISSUE:   if (!fifo_full) state_nx = WAIT;
      WAIT: begin
        if (ack_rise)         state_nx = ADV;
        else if (timeout_hit) state_nx = IDLE;
      end
      // The final entry may already be popped while we are still in ADV.
      ADV: begin
        if (!pair_last)    state_nx = ISSUE;
        else if (pop_last) state_nx = IDLE;
        else               state_nx = DRAIN;
      end
      DRAIN:   if (pop_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == IDLE) & run;
    issue  = (state == ISSUE) & ~fifo_full;
    push   = (state == WAIT) & ack_rise;
    tmo    = (state == WAIT) & ~ack_rise & timeout_hit;
    finish = ((state == ADV) & pair_last & pop_last) | ((state == DRAIN) & pop_last);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_q  <= 1'b0;
      i_q    <= '0;
      j_q    <= '0;
      timer  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ack_q  <= tw_ack;
      done_q <= finish;
      timer  <= (state == WAIT) ? timer + TMR_W'(1) : '0;
      if (accept) begin
        i_q    <= '0;
        j_q    <= '0;
        err_q  <= 1'b0;
        busy_q <= 1'b1;
      end
      if (tmo) begin
        err_q  <= 1'b1;
        busy_q <= 1'b0;
      end
      if (finish) busy_q <= 1'b0;
      if ((state == ADV) && !pair_last) begin
        if (j_end) begin
          j_q <= '0;
          i_q <= i_q + IDX_W'(1);
        end else begin
          j_q <= j_q + IDX_W'(1);
        end
      end
    end
  end

  tw_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (push_ent),
    .dout    (head_ent),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign tw_j        = j_q;
  assign tw_i        = i_q;
  assign tw_N        = IDX_W'(N_PTS);
  assign tw_start    = issue;
  assign tw_valid    = ~fifo_empty;
  assign tw_out      = tw_valid ? head_tw    : '0;
  assign tw_stage    = tw_valid ? head_stage : '0;
  assign tw_index    = tw_valid ? head_index : '0;
  assign tw_last     = tw_valid & head_last;
  assign dbg_state   = state;
  assign dbg_count   = fifo_count;

endmodule

// File: doc/tw_fetch_sequencer.md
Name: tw_fetch_sequencer

Overview:
- Initiator side of the twiddle-generator request/ack interface.
- Walks every (stage i, index j) pair an N-point NTT needs and drives j/i/N plus a start pulse into the twiddle generator.
- Waits for the generator's ack, captures the 25-bit twiddle, and buffers it in a small FIFO for the butterfly datapath under valid/ready.
- Sits between the NTT top-level controller (run/done) and the on-the-fly twiddle generator.

Parameters:
- IDX_W, 5, width of j, i, N and of the tagging fields.
- TW_W, 25, twiddle word width.
- N_PTS, 8, transform size; must be a power of two, ≤ 2^(IDX_W-1).
- LOGN, 3, number of stages, equal to log2(N_PTS).
- FIFO_DEPTH, 4, output buffer depth; must be a power of two ≥ 2.
- TIMEOUT_CYC, 64, maximum WAIT cycles before the error is raised.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  one-cycle pulse that starts a transform's twiddle sequence.
- busy  out  1  high from the cycle after an accepted run until the done pulse.
- done  out  1  one-cycle pulse when the last twiddle has been popped.
- err_timeout  out  1  sticky; cleared only by the next accepted run or by reset.
- tw_j  out  IDX_W  index j presented to the generator.
- tw_i  out  IDX_W  stage i presented to the generator.
- tw_N  out  IDX_W  constant N_PTS.
- tw_start  out  1  one-cycle request pulse to the generator.
- tw_ack  in  1  generator ack, level-type; may stay high for several cycles.
- tw_data  in  TW_W  generator twiddle output; valid when tw_ack rises.
- tw_valid  out  1  FIFO non-empty.
- tw_ready  in  1  butterfly accepts; a pop occurs when tw_valid & tw_ready.
- tw_out  out  TW_W  twiddle at the FIFO head.
- tw_stage  out  IDX_W  stage tag of the head entry.
- tw_index  out  IDX_W  j tag of the head entry.
- tw_last  out  1  head entry is the final twiddle of the transform.

Behaviour:
- Reset: async on reset_n low. All outputs 0 except tw_N = N_PTS. FIFO is emptied, FSM goes to IDLE. Reset mid-transaction abandons the request; any later generator ack is ignored because the FSM is in IDLE.
- Sequence: for i = 0..LOGN-1, j = 0..(N_PTS>>(i+1))-1, in that order; N_PTS-1 requests in total. For N_PTS=8 the pairs are (0,0)(0,1)(0,2)(0,3)(1,0)(1,1)(2,0).
- At most one request is outstanding at a time.
- Ack edge detection: a registered copy ack_q; ack_rise = tw_ack & ~ack_q. Only ack_rise counts. A held-high ack never pushes twice.
- FSM states:
  - IDLE: busy=0. On run, clear i, j and err_timeout, set busy → ISSUE.
  - ISSUE: if FIFO count < FIFO_DEPTH, assert tw_start for exactly one cycle with tw_j/tw_i driven → WAIT. Otherwise stall with tw_start=0.
  - WAIT: tw_j/tw_i held stable. The timer increments each cycle.
    - On ack_rise, push {tw_data, i, j, last} → ADV.
    - If the timer reaches TIMEOUT_CYC, set err_timeout, clear busy, leave the FIFO contents intact → IDLE.
    - ack_rise on the same cycle as the timer expiring: the ack wins.
  - ADV: if the pair just pushed was the last → DRAIN. Otherwise advance (j wraps to 0 and i increments at the stage boundary) → ISSUE.
  - DRAIN: when the popped entry has tw_last=1, pulse done, clear busy → IDLE.
- Latency: ISSUE to tw_start is 0 cycles when the FIFO is not full. A push becomes visible on tw_valid the cycle after ack_rise.
- FIFO: push and pop in the same cycle are both honoured and the count is unchanged. Pop when empty is ignored. Push is never attempted when full, guaranteed by the ISSUE check. Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- run while busy is ignored.
- tw_ready is independent of the FSM; popping continues in every state.

Decomposition:
- Shared package tw_pkg holds:
  - FSM state enum: IDLE, ISSUE, WAIT, ADV, DRAIN.
  - IDX_W/TW_W defaults.
  - Packed entry struct {tw, stage, index, last}.
- One sub-module: tw_fifo. It is a synchronous FIFO with the same async active-low reset, push/pop/full/empty/count ports, and is parameterised by entry width and depth.

Test Plan:
- Nominal N=8, tw_ready=1; the model generator acks 5 cycles after tw_start with tw_data=100+k for request k → 7 pushes in the pair order above, tw_out 100..106, tw_last only on (2,0), a single done pulse, busy low after done.
- Backpressure: tw_ready=0 → exactly 4 tw_start pulses, FSM stalls in ISSUE. Raise tw_ready → remaining 3 requests issue and all 7 entries emerge in order.
- Timeout: TIMEOUT_CYC=16, no ack → err_timeout=1 and busy=0 after 16 WAIT cycles, no further tw_start. A following run clears err_timeout.
- Ack held high 10 cycles → exactly one push per request, and the next tw_start follows ADV.
- run pulsed twice (second pulse mid-sequence) → ignored, still 7 requests. reset_n low during WAIT → all outputs 0, tw_valid=0, the late ack causes no push.
- Simultaneous push and pop with FIFO at 3 entries → count stays 3, order preserved.
